// File: rtl/spi_tx_scheduler.sv
// Chooses the next byte for the SPI shifter: response port, buffered stream FIFO, or filler byte.
// Build option SPI_TX_SCHED_RR_EN: response and stream alternate when both have data.
module spi_tx_scheduler #(
   parameter int         DEPTH = 16,
   parameter logic [7:0] FILL  = 8'hFF,
   parameter int         LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          csn_active,
   input  logic          rx_stb,
   input  logic          rsp_valid,
   input  logic [7:0]    rsp_data,
   output logic          rsp_ready,
   input  logic          str_valid,
   input  logic [7:0]    str_data,
   output logic          str_ready,
   output logic [7:0]    tx_data,
   output logic          tx_stb,
   input  logic          tx_busy,
   output logic [LW-1:0] fifo_level,
   output logic [7:0]    fill_cnt,
   output logic          late
);

   // state  | meaning
   // S_IDLE | chip select inactive, nothing scheduled
   // S_ARM  | select next byte as soon as the exporter is free
   // S_WAIT | byte handed off, waiting for the SPI byte boundary

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ARM  = 2'd1,
      S_WAIT = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          tx_stb_q, tx_stb_d;
   logic [7:0]    fill_cnt_q, fill_cnt_d;
   logic          late_q, late_d;

   logic fifo_empty;
   logic fifo_full;
   logic push;
   logic pop;
   logic can_select;
   logic rsp_wins;
   logic sel_rsp;
   logic sel_str;
   logic sel_fill;

   assign fifo_empty = (level_q == '0);
   assign fifo_full  = (level_q == LW'(DEPTH));
   assign push       = str_valid && !fifo_full;
   assign pop        = sel_str;
   assign can_select = (state_q == S_ARM) && csn_active && !tx_busy;

`ifdef SPI_TX_SCHED_RR_EN
   // last_rsp_q = 1 when the response port won the most recent non-fill grant
   logic last_rsp_q, last_rsp_d;

   assign rsp_wins = rsp_valid && (fifo_empty || !last_rsp_q);

   always_comb begin
      last_rsp_d = last_rsp_q;
      if (sel_rsp) begin
         last_rsp_d = 1'b1;
      end else if (sel_str) begin
         last_rsp_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_rsp_q <= 1'b0;
      end else begin
         last_rsp_q <= last_rsp_d;
      end
   end
`else
   assign rsp_wins = rsp_valid;
`endif

   always_comb begin
      sel_rsp  = 1'b0;
      sel_str  = 1'b0;
      sel_fill = 1'b0;
      if (can_select) begin
         if (rsp_wins) begin
            sel_rsp = 1'b1;
         end else if (!fifo_empty) begin
            sel_str = 1'b1;
         end else begin
            sel_fill = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      late_d  = late_q;
      case (state_q)
         S_IDLE: begin
            if (csn_active) begin
               late_d  = 1'b0;
               state_d = S_ARM;
            end
         end
         S_ARM: begin
            if (rx_stb) begin
               late_d = 1'b1;
            end
            if (!csn_active) begin
               state_d = S_IDLE;
            end else if (sel_rsp || sel_str || sel_fill) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (!csn_active) begin
               state_d = S_IDLE;
            end else if (rx_stb) begin
               state_d = S_ARM;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      tx_data_d  = tx_data_q;
      tx_stb_d   = sel_rsp || sel_str || sel_fill;
      fill_cnt_d = fill_cnt_q;
      if (sel_rsp) begin
         tx_data_d = rsp_data;
      end else if (sel_str) begin
         tx_data_d = mem_q[rd_ptr_q];
      end else if (sel_fill) begin
         tx_data_d = FILL;
         if (fill_cnt_q != 8'hFF) begin
            fill_cnt_d = fill_cnt_q + 8'd1;
         end
      end
   end

   // Pointers are AW bits wide, so DEPTH being a power of two gives the wrap for free
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
         level_d = level_q + LW'(1);
      end else if (pop && !push) begin
         level_d = level_q - LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= str_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         tx_data_q  <= FILL;
         tx_stb_q   <= 1'b0;
         fill_cnt_q <= 8'd0;
         late_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         tx_data_q  <= tx_data_d;
         tx_stb_q   <= tx_stb_d;
         fill_cnt_q <= fill_cnt_d;
         late_q     <= late_d;
      end
   end

   assign rsp_ready  = sel_rsp;
   assign str_ready  = !fifo_full;
   assign tx_data    = tx_data_q;
   assign tx_stb     = tx_stb_q;
   assign fifo_level = level_q;
   assign fill_cnt   = fill_cnt_q;
   assign late       = late_q;

endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Scoreboard bench for spi_tx_scheduler: driver predicts each transmitted byte from a queue model,
// a negedge monitor compares every tx_stb against the expected-byte queue.
module tb_spi_tx_scheduler;
   localparam int DEPTH = 16;
   localparam int LW    = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          csn_active;
   logic          rx_stb;
   logic          rsp_valid;
   logic [7:0]    rsp_data;
   logic          rsp_ready;
   logic          str_valid;
   logic [7:0]    str_data;
   logic          str_ready;
   logic [7:0]    tx_data;
   logic          tx_stb;
   logic          tx_busy;
   logic [LW-1:0] fifo_level;
   logic [7:0]    fill_cnt;
   logic          late;

   spi_tx_scheduler #(.DEPTH(DEPTH), .FILL(8'hFF), .LW(LW)) dut (
      .clk(clk), .rst(rst), .csn_active(csn_active), .rx_stb(rx_stb),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
      .str_valid(str_valid), .str_data(str_data), .str_ready(str_ready),
      .tx_data(tx_data), .tx_stb(tx_stb), .tx_busy(tx_busy),
      .fifo_level(fifo_level), .fill_cnt(fill_cnt), .late(late)
   );

   always #5 clk = ~clk;

   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] exp_q[$];
   logic [7:0] model_fifo[$];
   int         fill_m;
   bit         late_m;
   bit         rr_last_m;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every strobe must match the next byte the model predicted
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && tx_stb) begin
            if (exp_q.size() == 0) check("tx_stb_unexpected", tx_stb, 0);
            else check("tx_data", tx_data, exp_q.pop_front());
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1; csn_active = 1'b0; rx_stb = 1'b0; rsp_valid = 1'b0; rsp_data = 8'h00;
      str_valid = 1'b0; str_data = 8'h00; tx_busy = 1'b0;
      #1;
      model_fifo.delete(); fill_m = 0; late_m = 1'b0; rr_last_m = 1'b0;
      check("rst_tx_data", tx_data, 8'hFF);
      check("rst_tx_stb", tx_stb, 0);
      check("rst_rsp_ready", rsp_ready, 0);
      check("rst_fifo_level", fifo_level, 0);
      check("rst_fill_cnt", fill_cnt, 0);
      check("rst_late", late, 0);
      check("rst_str_ready", str_ready, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic push_byte(input logic [7:0] d);
      bit acc;
      acc = (model_fifo.size() < DEPTH);
      str_valid = 1'b1; str_data = d;
      #1;
      check("str_ready", str_ready, acc);
      @(posedge clk);
      if (acc) model_fifo.push_back(d);
      #1;
      str_valid = 1'b0;
   endtask

   // One byte slot: starts from IDLE (first) or WAIT, ends one cycle after the selection edge
   task automatic do_slot(input bit first, input bit use_rsp, input logic [7:0] rb,
                          input int nb, input bit late_pulse);
      bit         take_rsp;
      logic [7:0] e;
`ifdef SPI_TX_SCHED_RR_EN
      take_rsp = use_rsp && (model_fifo.size() == 0 || !rr_last_m);
`else
      take_rsp = use_rsp;
`endif
      if (take_rsp) e = rb;
      else if (model_fifo.size() != 0) e = model_fifo[0];
      else e = 8'hFF;
      rsp_valid = use_rsp; rsp_data = rb; tx_busy = (nb > 0);
      if (first) csn_active = 1'b1;
      else rx_stb = 1'b1;
      @(posedge clk); #1;
      rx_stb = 1'b0;
      if (first) late_m = 1'b0;
      check("stb_early", tx_stb, 0);
      for (int i = 0; i < nb; i++) begin
         if (late_pulse && i == 0) begin
            rx_stb = 1'b1; late_m = 1'b1;
         end
         @(posedge clk); #1;
         rx_stb = 1'b0;
         check("busy_stb", tx_stb, 0);
         check("busy_rsp_ready", rsp_ready, 0);
         check("busy_level", fifo_level, model_fifo.size());
      end
      tx_busy = 1'b0;
      #1;
      check("rsp_ready", rsp_ready, take_rsp);
      exp_q.push_back(e);
      @(posedge clk); #1;
      rsp_valid = 1'b0;
      if (take_rsp) rr_last_m = 1'b1;
      else if (model_fifo.size() != 0) begin
         void'(model_fifo.pop_front());
         rr_last_m = 1'b0;
      end else if (fill_m < 255) fill_m++;
      check("tx_stb", tx_stb, 1);
      check("fill_cnt", fill_cnt, fill_m);
      check("fifo_level", fifo_level, model_fifo.size());
      check("late", late, late_m);
   endtask

   task automatic end_session(input bit with_rx);
      csn_active = 1'b0;
      if (with_rx) rx_stb = 1'b1;
      @(posedge clk); #1;
      rx_stb = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("idle_level", fifo_level, model_fifo.size());
      check("idle_late", late, late_m);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      miscompares++;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1);
   end

   initial begin
      int ns;
      do_reset();

      // Filler only: FF with fill_cnt counting 1..4
      do_slot(1'b1, 1'b0, 8'h00, 0, 1'b0);
      for (int i = 0; i < 3; i++) do_slot(1'b0, 1'b0, 8'h00, 0, 1'b0);
      end_session(1'b0);

      // Stream order 11, 22, 33 then filler
      push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
      check("level_three", fifo_level, 3);
      do_slot(1'b1, 1'b0, 8'h00, 0, 1'b0);
      for (int i = 0; i < 3; i++) do_slot(1'b0, 1'b0, 8'h00, 0, 1'b0);
      end_session(1'b0);

      // Response against stream head
      push_byte(8'hA0);
      do_slot(1'b1, 1'b1, 8'h5A, 0, 1'b0);
      do_slot(1'b0, 1'b1, 8'h5B, 0, 1'b0);
      do_slot(1'b0, 1'b1, 8'h5B, 0, 1'b0);
      do_slot(1'b0, 1'b0, 8'h00, 0, 1'b0);
      end_session(1'b0);

      // Full FIFO: 17th push refused, one pop reopens
      for (int i = 0; i < DEPTH + 1; i++) push_byte(8'($urandom));
      check("full_level", fifo_level, DEPTH);
      check("full_str_ready", str_ready, 0);
      do_slot(1'b1, 1'b0, 8'h00, 0, 1'b0);
      check("after_pop_str_ready", str_ready, 1);

      // Exporter busy, then late detection, then csn drop in WAIT keeps FIFO
      do_slot(1'b0, 1'b0, 8'h00, 5, 1'b0);
      do_slot(1'b0, 1'b0, 8'h00, 2, 1'b1);
      end_session(1'b0);
      do_slot(1'b1, 1'b0, 8'h00, 0, 1'b0);
      end_session(1'b1);

      // Randomised sessions
      for (int s = 0; s < 25; s++) begin
         ns = $urandom_range(1, 10);
         for (int k = 0; k < ns; k++) begin
            for (int p = $urandom_range(0, 3); p > 0; p--) push_byte(8'($urandom));
            do_slot(k == 0, ($urandom_range(0, 2) == 0), 8'($urandom),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                    ($urandom_range(0, 4) == 0));
         end
         end_session($urandom_range(0, 1) == 1);
      end

      // Drain and saturate the fill counter
      do_slot(1'b1, 1'b0, 8'h00, 0, 1'b0);
      for (int i = 0; i < 275; i++) do_slot(1'b0, 1'b0, 8'h00, 0, 1'b0);
      check("fill_saturated", fill_cnt, 255);

      // Reset in the middle of a transfer
      push_byte(8'h77);
      do_reset();
      do_slot(1'b1, 1'b0, 8'h00, 0, 1'b0);
      end_session(1'b0);

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/spi_tx_scheduler.md
Name: spi_tx_scheduler

Overview:
- Wishbone-clock-domain controller that decides which byte the SPI peripheral transmits next.
- Arbitrates between two requesters:
  - a single-byte response port (high priority);
  - a buffered stream port with an internal FIFO.
- Sends a filler byte when neither requester has data.
- Paced by the byte-boundary strobe returned from the SPI domain; each selected byte goes to the clock-domain exporter feeding the SPI shifter.

Parameters:
- DEPTH, 16, stream FIFO depth in bytes; power of two, at least 2.
- FILL, 8'hFF, byte sent when no source has data.
- LW, $clog2(DEPTH)+1, width of fifo_level.

Ports:
- clk  in  1  system (wishbone) clock.
- rst  in  1  asynchronous, active-high reset.
- csn_active  in  1  chip select active, already synchronised to clk.
- rx_stb  in  1  one-cycle pulse per completed SPI byte, already synchronised.
- rsp_valid  in  1  response byte offered.
- rsp_data  in  8  response byte.
- rsp_ready  out  1  response byte consumed this cycle.
- str_valid  in  1  stream byte offered.
- str_data  in  8  stream byte.
- str_ready  out  1  FIFO can accept a byte.
- tx_data  out  8  byte handed to the CDC exporter.
- tx_stb  out  1  one-cycle strobe; tx_data is valid.
- tx_busy  in  1  exporter still crossing the previous byte.
- fifo_level  out  LW  current FIFO occupancy.
- fill_cnt  out  8  fill bytes sent; saturating.
- late  out  1  sticky: SPI consumed a byte before the next one was loaded.

Behaviour:
- Reset values:
  - FSM in IDLE.
  - FIFO empty; fifo_level=0.
  - tx_data=FILL; tx_stb=0; rsp_ready=0.
  - fill_cnt=0; late=0.
  - str_ready=1.
- FIFO:
  - push when str_valid && str_ready; str_ready = !full.
  - pop only on a stream selection.
  - push and pop in the same cycle leave the level unchanged.
  - pointers wrap modulo DEPTH.
  - the FIFO accepts pushes in every state, including IDLE.
- IDLE:
  - tx_stb=0.
  - on csn_active=1: clear late, go to ARM.
- ARM:
  - if tx_busy=0, select the source in this order:
    1. rsp_valid: tx_data=rsp_data, rsp_ready=1.
    2. FIFO non-empty: tx_data=FIFO head, pop.
    3. otherwise: tx_data=FILL, fill_cnt+1, saturating at 255.
  - on selection: tx_stb=1 for exactly one cycle, go to WAIT.
  - if tx_busy=1, stay in ARM; nothing is consumed.
  - tx_data and tx_stb are registered, so the strobe appears the cycle after the decision.
  - rx_stb while in ARM sets late=1.
- WAIT:
  - rx_stb, go to ARM.
  - tx_data holds its last value.
- csn_active=0 in any state: go to IDLE next cycle.
  - An unstrobed selection is never made; a strobed byte is considered sent.
  - The FIFO is not flushed.
- rx_stb in the same cycle as a csn_active fall: IDLE wins.
- rsp_ready is asserted only in the selecting cycle; rsp_data must be stable while rsp_valid is high.
- Reset mid-transfer: immediate return to reset values; FIFO contents are lost.
- Latency, csn_active rise to first tx_stb: 2 cycles when tx_busy=0.

Optional Feature:
- SPI_TX_SCHED_RR_EN defined:
  - when rsp_valid and the FIFO are both non-empty, selection alternates between them, starting with rsp after reset.
  - a 1-bit last-grant register updates on every non-fill selection.
- Undefined: fixed priority, with rsp always first.

Test Plan:
- Reset, csn_active=1, no sources, tx_busy=0 -> tx_stb 2 cycles later with tx_data=8'hFF; fill_cnt=1; three rx_stb pulses -> fill_cnt=4.
- Push 8'h11, 8'h22, 8'h33 to the stream; csn_active=1; rx_stb after each strobe -> tx_data sequence 11, 22, 33, FF; fifo_level 3→0.
- Stream FIFO holds 8'hA0, rsp_valid with 8'h5A:
  - fixed priority -> 5A then A0;
  - with RR_EN and rsp held valid with 8'h5A, 8'h5B -> 5A, A0, 5B.
- Push 16 bytes -> str_ready=0 and fifo_level=16; a 17th push is ignored; one pop -> str_ready=1.
- tx_busy=1 held 5 cycles in ARM -> no tx_stb, FIFO level unchanged; tx_busy falls -> tx_stb next cycle.
- rx_stb while in ARM with tx_busy=1 -> late=1; csn_active 0→1 -> late=0; csn_active dropped in WAIT -> IDLE, FIFO retains remaining bytes.
